rename_unit: RTL and testbench
==============================

# rename_unit

Parametrised register-renaming stage for the out-of-order core. It replaces the fixed 32→64 rename logic with configurable architectural and physical register counts and an internal bitmap free list. It adds a valid/ready allocation handshake, commit-time freeing, and optional flush recovery from a committed map. It sits between decode and the ROB/issue queues and renames one instruction per cycle.

## Interface
- `ARCH_REGS`, 32: architectural register count; register 0 is hard-wired zero.
- `PHYS_REGS`, 64: physical register count; must be greater than `ARCH_REGS`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  instruction presented for rename.
- `ready`  out  1  rename can accept the presented instruction this cycle (combinational).
- `dest_wr`  in  1  instruction writes a destination.
- `src_arch_reg1`, `src_arch_reg2`, `dest_arch_reg`  in  ARCH_W  architectural indices.
- `src_phys_reg1`, `src_phys_reg2`  out  PHYS_W  renamed sources (registered).
- `dest_phys_reg`  out  PHYS_W  newly allocated destination (registered).
- `old_dest_phys_reg`  out  PHYS_W  previous mapping of the destination, passed to the ROB for freeing (registered).
- `rename_valid`  out  1  outputs valid this cycle.
- `commit_valid`  in  1  ROB retires a destination-writing instruction.
- `commit_arch_reg`  in  ARCH_W  retired destination.
- `commit_phys_reg`  in  PHYS_W  retired new mapping.
- `commit_old_phys_reg`  in  PHYS_W  register to return to the free list.
- `flush`  in  1  present only with `RENAME_RECOVERY_EN`.
- `free_count`  out  PHYS_W+1  number of free physical registers (registered state).

Widths: ARCH_W = $clog2(ARCH_REGS), PHYS_W = $clog2(PHYS_REGS).

## Operation
- **Reset:**
  - RAT[i] = i.
  - Physical 0..ARCH_REGS-1 busy; ARCH_REGS..PHYS_REGS-1 free.
  - `free_count` = PHYS_REGS-ARCH_REGS.
  - All registered outputs 0; `rename_valid` 0.
- **Allocating instruction:** `dest_wr` = 1 and `dest_arch_reg` != 0.
- **ready:** 0 only when an allocating instruction is presented and the free list is empty. Otherwise 1.
- **Fire:** `valid` && `ready`.
  - Sources are read from the current RAT and registered.
  - The allocating instruction takes the lowest-index free physical register (priority encoder). It marks that register busy, writes RAT[dest], and registers `old_dest_phys_reg` = prior RAT[dest].
- **Non-allocating instruction:** `dest_phys_reg` = 0, `old_dest_phys_reg` = 0, and no RAT or free-list change.
- **Source reads:** use the RAT before this cycle's write. A source equal to the same instruction's destination gets the old mapping.
- **Architectural register 0:** never remapped; sources of x0 always read p0.
- **Commit:** `commit_valid` sets `commit_old_phys_reg` free.
  - A commit with `commit_old_phys_reg` = 0 is ignored.
  - Freeing an already-free register is a verification error and is asserted in simulation.
- **Same-cycle allocate and free:** both apply. `free_count` nets ±0. The freed register is not allocatable until the next cycle; there is no bypass.

## Timing
- Rename latency is 1 cycle: fire at edge N gives `rename_valid` = 1 and outputs valid in the cycle after N.
- Back-to-back renames see each other's RAT writes with no bubble.
- Stall: `ready` = 0 holds the RAT and free list, and drives `rename_valid` = 0 next cycle. Decode holds its inputs.
- `ready` rises in the cycle after the commit edge that frees a register.
- Reset mid-stream discards in-flight outputs; `rename_valid` = 0 the next cycle.

## Configuration
- Macro: `RENAME_RECOVERY_EN`.
- **Defined:**
  - Adds the `flush` port and a committed RAT (CRAT, reset to identity). Each commit writes CRAT[commit_arch_reg] = commit_phys_reg.
  - Flush at edge N, starting from post-commit CRAT (a commit in the same cycle is applied first):
    - RAT ← CRAT.
    - Free bitmap ← all registers not referenced by CRAT.
    - `free_count` is recomputed.
    - `rename_valid` = 0 in the next cycle.
  - A rename in the flush cycle is dropped.
- **Undefined:** no `flush` port, no CRAT, and `commit_arch_reg`/`commit_phys_reg` are unused. Misprediction recovery is the ROB's responsibility.

## Structure
- `rename_pkg`: ARCH_W/PHYS_W helper functions, the physical-tag typedef, and the reset-mapping constant.
- Sub-module `rename_free_list`: the bitmap, lowest-index allocation encoder, commit free port, bulk-load port for flush, and `free_count`.
- RAT and CRAT are flop arrays in the top module.
- Elaboration check: PHYS_REGS > ARCH_REGS.

## Test plan
- Reset, then rename with dest x5, src x5/x6 → next cycle: src p5/p6, dest p32, old p5; `free_count` = 31.
- Two back-to-back renames writing x5 → second gives old p32, dest p33; a third instruction reading x5 gets p33.
- Allocate 32 times without commit → `ready` = 0 on the 33rd attempt and `rename_valid` stays 0. Commit freeing p5 → `ready` = 1 the next cycle, and the allocation returns p5.
- dest x0 or `dest_wr` = 0 → `dest_phys_reg` = 0 and `free_count` unchanged. A commit with old p0 is ignored.
- Same-cycle allocate and free (p40) with one free register remaining → the allocation takes the existing free register, not p40; `free_count` unchanged.
- `RENAME_RECOVERY_EN`: rename x1→p32 and x2→p33, commit x1 with old p1, then flush in the same cycle as committing x2 → RAT x1 = p32, x2 = p33; p1 and p2 free; `free_count` = 32.

Source files
------------

// File: rtl/rename_pkg.sv
// rename_pkg: shared helpers for the register-renaming stage.
//   arch_w()/phys_w()   index widths derived from register counts
//   phys_tag_t          physical tag for the default 64-entry file
//   reset_mapping()     identity arch->phys mapping used at reset
package rename_pkg;

  localparam int unsigned PHYS_REGS_DEF = 32'd64;

  function automatic int unsigned arch_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  function automatic int unsigned phys_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  typedef logic [$clog2(PHYS_REGS_DEF)-1:0] phys_tag_t;

  // Architectural register i maps to physical register i out of reset.
  function automatic int unsigned reset_mapping(input int unsigned arch_idx);
    return arch_idx;
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// rename_free_list: bitmap free list for physical registers.
//   clk_i, reset_i  clock / synchronous active-high reset
//   alloc_i         take alloc_idx_o this cycle (caller guarantees !empty_o)
//   free_i          return free_idx_i this cycle
//   load_i          overwrite bitmap with load_map_i (flush recovery)
//   empty_o         no register free
//   alloc_idx_o     lowest-index free register
//   free_count_o    number of free registers (registered)
module rename_free_list
  import rename_pkg::*;
#(
  parameter int unsigned PHYS_REGS = 32'd64,
  parameter int unsigned ARCH_REGS = 32'd32,
  localparam int unsigned PHYS_W   = phys_w(PHYS_REGS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 alloc_i,
  input  logic                 free_i,
  input  logic [PHYS_W-1:0]    free_idx_i,
  input  logic                 load_i,
  input  logic [PHYS_REGS-1:0] load_map_i,
  output logic                 empty_o,
  output logic [PHYS_W-1:0]    alloc_idx_o,
  output logic [PHYS_W:0]      free_count_o
);

  logic [PHYS_REGS-1:0] free_q, free_d;
  logic [PHYS_W:0]      count_q, count_d;
  logic [PHYS_W:0]      load_count_s;

  // Lowest-index priority encoder: scan downwards so the lowest hit wins.
  always_comb begin
    alloc_idx_o = '0;
    for (int p = PHYS_REGS - 1; p >= 0; p--) begin
      alloc_idx_o = free_q[p] ? PHYS_W'(p) : alloc_idx_o;
    end
  end

  assign empty_o      = ~|free_q;
  assign free_count_o = count_q;

  // Population count of the bulk-load map.
  always_comb begin
    load_count_s = '0;
    for (int p = 0; p < PHYS_REGS; p++) begin
      load_count_s = load_count_s + (PHYS_W+1)'(load_map_i[p]);
    end
  end

  // Next bitmap and count; a same-cycle free is visible only next cycle.
  always_comb begin
    free_d  = free_q;
    count_d = count_q;
    if (load_i) begin
      free_d  = load_map_i;
      count_d = load_count_s;
    end else begin
      if (alloc_i) begin
        free_d[alloc_idx_o] = 1'b0;
      end else begin
        free_d = free_d;
      end
      if (free_i) begin
        free_d[free_idx_i] = 1'b1;
      end else begin
        free_d = free_d;
      end
      if (alloc_i && !free_i) begin
        count_d = count_q - (PHYS_W+1)'(1);
      end else if (free_i && !alloc_i) begin
        count_d = count_q + (PHYS_W+1)'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // State register: registers below ARCH_REGS start busy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int p = 0; p < PHYS_REGS; p++) begin
        free_q[p] <= (p >= ARCH_REGS);
      end
      count_q <= (PHYS_W+1)'(PHYS_REGS - ARCH_REGS);
    end else begin
      free_q  <= free_d;
      count_q <= count_d;
    end
  end

  rename_free_list_chk #(.PHYS_REGS(PHYS_REGS)) u_chk (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .free_i     (free_i),
    .free_idx_i (free_idx_i),
    .free_map_i (free_q)
  );

endmodule

// File: rtl/rename_free_list_chk.sv
// rename_free_list_chk: simulation checker for the free list.
//   clk_i, reset_i  clock / synchronous active-high reset
//   free_i          a register is being returned this cycle
//   free_idx_i      register being returned
//   free_map_i      current free bitmap (1 = free)
module rename_free_list_chk #(
  parameter int unsigned PHYS_REGS = 32'd64,
  localparam int unsigned PHYS_W   = rename_pkg::phys_w(PHYS_REGS)
) (
  input logic                 clk_i,
  input logic                 reset_i,
  input logic                 free_i,
  input logic [PHYS_W-1:0]    free_idx_i,
  input logic [PHYS_REGS-1:0] free_map_i
);

  // Returning a register that is already free means the ROB lost track of it.
  always_ff @(posedge clk_i) begin
    if (!reset_i && free_i) begin
      assert (!free_map_i[free_idx_i])
        else $error("rename free list: double free of p%0d", free_idx_i);
    end
  end

endmodule

// File: rtl/rename_unit.sv
// rename_unit: one-instruction-per-cycle register renaming stage.
// Optional feature macro: RENAME_RECOVERY_EN (adds flush port + committed RAT).
//   clk, reset                       clock / synchronous active-high reset
//   valid / ready                    rename handshake (ready is combinational)
//   dest_wr, dest_arch_reg           destination request
//   src_arch_reg1/2                  source indices
//   src_phys_reg1/2, dest_phys_reg,  registered rename results,
//   old_dest_phys_reg, rename_valid  valid the cycle after fire
//   commit_*                         ROB retirement, returns old mapping
//   flush                            (RENAME_RECOVERY_EN) restore from CRAT
//   free_count                       number of free physical registers
module rename_unit
  import rename_pkg::*;
#(
  parameter int unsigned ARCH_REGS = 32'd32,
  parameter int unsigned PHYS_REGS = 32'd64,
  localparam int unsigned ARCH_W   = arch_w(ARCH_REGS),
  localparam int unsigned PHYS_W   = phys_w(PHYS_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic              dest_wr,
  input  logic [ARCH_W-1:0] src_arch_reg1,
  input  logic [ARCH_W-1:0] src_arch_reg2,
  input  logic [ARCH_W-1:0] dest_arch_reg,
  output logic [PHYS_W-1:0] src_phys_reg1,
  output logic [PHYS_W-1:0] src_phys_reg2,
  output logic [PHYS_W-1:0] dest_phys_reg,
  output logic [PHYS_W-1:0] old_dest_phys_reg,
  output logic              rename_valid,
  input  logic              commit_valid,
  input  logic [ARCH_W-1:0] commit_arch_reg,
  input  logic [PHYS_W-1:0] commit_phys_reg,
  input  logic [PHYS_W-1:0] commit_old_phys_reg,
`ifdef RENAME_RECOVERY_EN
  input  logic              flush,
`endif
  output logic [PHYS_W:0]   free_count
);

  if (PHYS_REGS <= ARCH_REGS) begin : g_bad_cfg
    $error("rename_unit: PHYS_REGS must be greater than ARCH_REGS");
  end

  logic [PHYS_W-1:0] rat_q [ARCH_REGS];
  logic [PHYS_W-1:0] rat_d [ARCH_REGS];

  logic              alloc_instr_s, empty_s, fire_s, rename_fire_s, alloc_fire_s;
  logic              free_s, load_s;
  logic [PHYS_W-1:0] alloc_idx_s;
  logic [PHYS_REGS-1:0] load_map_s;

  logic [PHYS_W-1:0] src1_q, src2_q, dest_q, old_q;
  logic              rename_valid_q;

  assign alloc_instr_s = dest_wr && (dest_arch_reg != '0);
  assign ready         = !(valid && alloc_instr_s && empty_s);
  assign fire_s        = valid && ready;
  // p0 is permanently busy, so an old mapping of 0 carries nothing to free.
  assign free_s        = commit_valid && (commit_old_phys_reg != '0);

`ifdef RENAME_RECOVERY_EN
  logic [PHYS_W-1:0] crat_q [ARCH_REGS];
  logic [PHYS_W-1:0] crat_d [ARCH_REGS];
  logic [PHYS_REGS-1:0] ref_s;

  // A rename presented during a flush belongs to the squashed path.
  assign rename_fire_s = fire_s && !flush;
  assign load_s        = flush;

  // Committed map advances on every retirement; x0 stays on p0.
  always_comb begin
    crat_d = crat_q;
    if (commit_valid && (commit_arch_reg != '0)) begin
      crat_d[commit_arch_reg] = commit_phys_reg;
    end else begin
      crat_d = crat_d;
    end
  end

  // Free map after flush: everything the post-commit CRAT does not reference.
  always_comb begin
    ref_s = '0;
    for (int i = 0; i < ARCH_REGS; i++) begin
      ref_s[crat_d[i]] = 1'b1;
    end
    load_map_s = ~ref_s;
  end

  // Committed RAT register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        crat_q[i] <= PHYS_W'(reset_mapping(i));
      end
    end else begin
      crat_q <= crat_d;
    end
  end
`else
  logic unused_commit_s;

  assign rename_fire_s   = fire_s;
  assign load_s          = 1'b0;
  assign load_map_s      = '0;
  assign unused_commit_s = ^{commit_arch_reg, commit_phys_reg};
`endif

  assign alloc_fire_s = rename_fire_s && alloc_instr_s;

  // Speculative RAT update; sources this cycle read rat_q (pre-write).
  always_comb begin
    rat_d = rat_q;
    if (alloc_fire_s) begin
      rat_d[dest_arch_reg] = alloc_idx_s;
    end else begin
      rat_d = rat_d;
    end
`ifdef RENAME_RECOVERY_EN
    if (flush) begin
      rat_d = crat_d;
    end else begin
      rat_d = rat_d;
    end
`endif
    rat_d[0] = '0;
  end

  // RAT register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= PHYS_W'(reset_mapping(i));
      end
    end else begin
      rat_q <= rat_d;
    end
  end

  // Registered rename results; held when nothing fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      src1_q         <= '0;
      src2_q         <= '0;
      dest_q         <= '0;
      old_q          <= '0;
      rename_valid_q <= 1'b0;
    end else begin
      rename_valid_q <= rename_fire_s;
      if (rename_fire_s) begin
        src1_q <= rat_q[src_arch_reg1];
        src2_q <= rat_q[src_arch_reg2];
        dest_q <= alloc_instr_s ? alloc_idx_s : '0;
        old_q  <= alloc_instr_s ? rat_q[dest_arch_reg] : '0;
      end
    end
  end

  assign src_phys_reg1     = src1_q;
  assign src_phys_reg2     = src2_q;
  assign dest_phys_reg     = dest_q;
  assign old_dest_phys_reg = old_q;
  assign rename_valid      = rename_valid_q;

  rename_free_list #(.PHYS_REGS(PHYS_REGS), .ARCH_REGS(ARCH_REGS)) u_free_list (
    .clk_i        (clk),
    .reset_i      (reset),
    .alloc_i      (alloc_fire_s),
    .free_i       (free_s),
    .free_idx_i   (commit_old_phys_reg),
    .load_i       (load_s),
    .load_map_i   (load_map_s),
    .empty_o      (empty_s),
    .alloc_idx_o  (alloc_idx_s),
    .free_count_o (free_count)
  );

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: a reference model computes each cycle's
// expected response, pushes it to a scoreboard, and a monitor compares.
module tb_rename_unit;
  localparam int AR = 32;
  localparam int PR = 64;

  logic       clk = 1'b0;
  logic       reset, valid, dest_wr, commit_valid, ready, rename_valid;
  logic [4:0] src_arch_reg1, src_arch_reg2, dest_arch_reg, commit_arch_reg;
  logic [5:0] src_phys_reg1, src_phys_reg2, dest_phys_reg, old_dest_phys_reg;
  logic [5:0] commit_phys_reg, commit_old_phys_reg;
  logic [6:0] free_count;
  logic       flush;

  rename_unit #(.ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .dest_wr(dest_wr),
    .src_arch_reg1(src_arch_reg1), .src_arch_reg2(src_arch_reg2),
    .dest_arch_reg(dest_arch_reg), .src_phys_reg1(src_phys_reg1),
    .src_phys_reg2(src_phys_reg2), .dest_phys_reg(dest_phys_reg),
    .old_dest_phys_reg(old_dest_phys_reg), .rename_valid(rename_valid),
    .commit_valid(commit_valid), .commit_arch_reg(commit_arch_reg),
    .commit_phys_reg(commit_phys_reg), .commit_old_phys_reg(commit_old_phys_reg),
`ifdef RENAME_RECOVERY_EN
    .flush(flush),
`endif
    .free_count(free_count)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit rst; int s1; int s2; int d; int old; } exp_t;
  typedef struct { int arch; int phys; int old; } rob_t;

  exp_t sb[$];
  rob_t rob[$];
  int   rat[AR];
  int   crat[AR];
  bit   busy[PR];
  int   checks = 0;
  int   errors = 0;
  bit   last_stall = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nfree();
    int n = 0;
    for (int p = 0; p < PR; p++) if (!busy[p]) n++;
    return n;
  endfunction

  function automatic int lowest_free();
    for (int p = 0; p < PR; p++) if (!busy[p]) return p;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < AR; i++) begin rat[i] = i; crat[i] = i; end
    for (int p = 0; p < PR; p++) busy[p] = (p < AR);
    rob.delete();
  endfunction

  // One clock cycle: drive inputs, then at the falling edge check ready /
  // free_count against the model and advance the model to the next edge.
  task automatic drive(input bit rst, input bit v, input bit dw, input int d,
                       input int s1, input int s2, input bit cv, input int ca,
                       input int cp, input int co, input bit fl);
    exp_t e;
    bit   alloc, er, fire;
    int   p;
    reset = rst; valid = v; dest_wr = dw;
    dest_arch_reg = 5'(d); src_arch_reg1 = 5'(s1); src_arch_reg2 = 5'(s2);
    commit_valid = cv; commit_arch_reg = 5'(ca);
    commit_phys_reg = 6'(cp); commit_old_phys_reg = 6'(co);
    flush = fl;
    @(negedge clk);
    e = '{v: 1'b0, rst: rst, s1: 0, s2: 0, d: 0, old: 0};
    if (rst) begin
      model_reset();
      last_stall = 1'b0;
    end else begin
      chk("free_count", int'(free_count), nfree());
      alloc = dw && (d != 0);
      er    = !(v && alloc && nfree() == 0);
      chk("ready", int'(ready), int'(er));
      fire  = v && er && !fl;
      last_stall = v && !er;
      p = lowest_free();
      if (fire) begin
        e.v  = 1'b1;
        e.s1 = rat[s1];
        e.s2 = rat[s2];
        if (alloc) begin e.d = p; e.old = rat[d]; end
      end
      if (fire && alloc) begin
        rob.push_back('{arch: d, phys: p, old: rat[d]});
        busy[p] = 1'b1;
        rat[d]  = p;
      end
      if (cv && co != 0) busy[co] = 1'b0;
      if (cv && ca != 0) crat[ca] = cp;
      if (fl) begin
        for (int i = 0; i < AR; i++) rat[i] = crat[i];
        for (int q = 0; q < PR; q++) busy[q] = 1'b0;
        for (int i = 0; i < AR; i++) busy[crat[i]] = 1'b1;
        rob.delete();
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic ren(input bit dw, input int d, input int s1, input int s2);
    drive(1'b0, 1'b1, dw, d, s1, s2, 1'b0, 0, 0, 0, 1'b0);
  endtask

  // Rename plus retirement of the oldest in-flight allocation.
  task automatic ren_commit(input bit v, input bit dw, input int d, input int s1,
                            input int s2, input bit fl);
    rob_t r;
    r = rob.pop_front();
    drive(1'b0, v, dw, d, s1, s2, 1'b1, r.arch, r.phys, r.old, fl);
  endtask

  // Monitor: consumes one scoreboard entry per driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rename_valid", int'(rename_valid), int'(e.v));
        if (e.v || e.rst) begin
          chk("src_phys_reg1", int'(src_phys_reg1), e.s1);
          chk("src_phys_reg2", int'(src_phys_reg2), e.s2);
          chk("dest_phys_reg", int'(dest_phys_reg), e.d);
          chk("old_dest_phys_reg", int'(old_dest_phys_reg), e.old);
        end
      end
    end
  end

  initial begin
    bit v, dw, cv, fl, rst;
    int d, s1, s2, k;
    rob_t r;
    v = 1'b0; dw = 1'b0; d = 0; s1 = 0; s2 = 0;
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);

    // Basic rename, back-to-back writes of x5, then a reader of x5.
    ren(1'b1, 5, 5, 6);
    ren(1'b1, 5, 5, 0);
    ren(1'b0, 0, 5, 6);

    // Fill the free list, then stall with an allocating instruction.
    k = 0;
    while (nfree() > 0 && k < 100) begin
      ren(1'b1, 7 + (k % 25), k % 32, 5);
      k++;
    end
    ren(1'b1, 9, 1, 2);
    ren(1'b1, 9, 1, 2);
    ren_commit(1'b1, 1'b1, 9, 1, 2, 1'b0);   // frees p5, still stalled
    ren(1'b1, 9, 1, 2);                       // takes p5
    ren_commit(1'b0, 1'b0, 0, 0, 0, 1'b0);   // frees p32, one free left
    ren_commit(1'b1, 1'b1, 11, 3, 4, 1'b0);  // takes p32 while p7 is freed
    ren(1'b1, 12, 11, 12);                    // now p7 is allocatable

    // Non-allocating forms and a commit of p0.
    ren(1'b1, 0, 3, 0);
    ren(1'b0, 13, 13, 14);
    drive(1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b1, 0, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);

`ifdef RENAME_RECOVERY_EN
    // Recovery: commit x1, then flush in the same cycle as committing x2.
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    ren(1'b1, 1, 0, 0);
    ren(1'b1, 2, 0, 0);
    ren_commit(1'b0, 1'b0, 0, 0, 0, 1'b0);
    ren_commit(1'b1, 1'b1, 3, 1, 2, 1'b1);   // rename dropped by the flush
    ren(1'b0, 0, 1, 2);
    ren(1'b1, 3, 3, 1);
`endif

    // Reset while a rename is in flight.
    ren(1'b1, 20, 20, 21);
    drive(1'b1, 1'b1, 1'b1, 22, 22, 23, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);

    // Randomised traffic; decode holds its inputs while stalled.
    for (int n = 0; n < 2000; n++) begin
      if (!last_stall) begin
        v  = ($urandom % 4) != 0;
        dw = ($urandom % 4) != 0;
        d  = $urandom % AR;
        s1 = $urandom % AR;
        s2 = $urandom % AR;
      end
      cv = (rob.size() > 0) && (($urandom % 2) == 0);
      fl = 1'b0;
`ifdef RENAME_RECOVERY_EN
      fl = ($urandom % 60) == 0;
`endif
      rst = ($urandom % 500) == 0;
      if (cv) begin
        r = rob.pop_front();
        drive(rst, v, dw, d, s1, s2, 1'b1, r.arch, r.phys, r.old, fl);
      end else begin
        drive(rst, v, dw, d, s1, s2, 1'b0, 0, 0, 0, fl);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
